// File: rtl/systolic_ws_pkg.sv
// Shared types and helpers for the weight-stationary skew feeder.
// Holds the feeder state enum, pipeline depth and south latency helpers.
package systolic_ws_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int DEF_ROW_NUM = 8;
  localparam int DEF_COL_NUM = 8;
  localparam int PIPE_DEPTH  = DEF_ROW_NUM + DEF_COL_NUM;

  // Depth of the valid/last pipeline for a given array shape.
  function automatic int pipe_depth(
    input int rows,
    input int cols
  );
    return rows + cols;
  endfunction

  // Cycle (relative to the accept edge) in which souths[j] is valid.
  function automatic int south_latency(
    input int j,
    input int rows = DEF_ROW_NUM
  );
    return rows + j + 1;
  endfunction

endpackage

// File: rtl/systolic_ws_delay_line.sv
// Registered shift line of DEPTH stages, all stages exposed as taps.
// Ports: clk, rst_ni (async active-low), d_i, taps_o[DEPTH-1] oldest.
module systolic_ws_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic                        clk,
  input  logic                        rst_ni,
  input  logic [WIDTH-1:0]            d_i,
  output logic [DEPTH-1:0][WIDTH-1:0] taps_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign taps_o = stage_q;

endmodule

// File: rtl/systolic_ws_skew_feeder.sv
// Skewing feeder and result tracker for systolic_ws_pe_array.
// Ports: clk, reset (async active-low), in_valid/in_ready/in_last,
//   in_data[row], wests[row], norths[col], south_valid/south_last[col],
//   busy, done. Optional bias (in_bias[col]) with
//   SYSTOLIC_WS_FEEDER_BIAS_EN.
module systolic_ws_skew_feeder
  import systolic_ws_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 8,
  parameter int COL_NUM    = 8
) (
`ifdef SYSTOLIC_WS_FEEDER_BIAS_EN
  input  logic [DATA_WIDTH-1:0]   in_bias [0:COL_NUM-1],
`endif
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [DATA_WIDTH-1:0]   in_data [0:ROW_NUM-1],
  output logic [DATA_WIDTH-1:0]   wests   [0:ROW_NUM-1],
  output logic [4*DATA_WIDTH-1:0] norths  [0:COL_NUM-1],
  output logic [COL_NUM-1:0]      south_valid,
  output logic [COL_NUM-1:0]      south_last,
  output logic                    busy,
  output logic                    done
);

  localparam int PD = pipe_depth(ROW_NUM, COL_NUM);

  state_e state_q;
  logic   in_ready_q;
  logic   busy_q;
  logic   accept;

  assign accept   = in_valid && in_ready_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;

  // Row skew: row i sits i+1 registers from the input.
  for (genvar i = 0; i < ROW_NUM; i++) begin : g_row
    logic [DATA_WIDTH-1:0]   row_d;
    logic [i:0][DATA_WIDTH-1:0] row_taps;
    logic row_taps_unused;

    assign row_d = accept ? in_data[i] : '0;

    systolic_ws_delay_line #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (i + 1)
    ) u_row_dl (
      .clk    (clk),
      .rst_ni (reset),
      .d_i    (row_d),
      .taps_o (row_taps)
    );

    assign wests[i] = row_taps[i];
    assign row_taps_unused = ^row_taps;
  end

  // Valid/last tracker: bit 1 valid, bit 0 last.
  logic [1:0]         vl_d;
  logic [PD-1:0][1:0] vl_taps;
  logic               vl_taps_unused;

  assign vl_d = {accept, accept & in_last};

  systolic_ws_delay_line #(
    .WIDTH (2),
    .DEPTH (PD)
  ) u_vl_dl (
    .clk    (clk),
    .rst_ni (reset),
    .d_i    (vl_d),
    .taps_o (vl_taps)
  );

  assign vl_taps_unused = ^vl_taps;

  for (genvar j = 0; j < COL_NUM; j++) begin : g_col
    localparam int TAP = south_latency(j, ROW_NUM) - 1;

    assign south_valid[j] = vl_taps[TAP][1];
    assign south_last[j]  = vl_taps[TAP][0];

`ifdef SYSTOLIC_WS_FEEDER_BIAS_EN
    logic [DATA_WIDTH-1:0]   bias_d;
    logic [j:0][DATA_WIDTH-1:0] bias_taps;
    logic bias_taps_unused;

    assign bias_d = accept ? in_bias[j] : '0;

    // Column j bias meets the west data at PE(0,j).
    systolic_ws_delay_line #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (j + 1)
    ) u_bias_dl (
      .clk    (clk),
      .rst_ni (reset),
      .d_i    (bias_d),
      .taps_o (bias_taps)
    );

    assign norths[j] = {
      {(3*DATA_WIDTH){1'b0}},
      bias_taps[j]
    };
    assign bias_taps_unused = ^bias_taps;
`else
    assign norths[j] = '0;
`endif
  end

  assign done = south_valid[COL_NUM-1]
             && south_last[COL_NUM-1];

  // Batch sequencer; in_ready and busy are registered with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (in_last) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (accept && in_last) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (done) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_ws_skew_feeder.sv
// Scoreboard bench for systolic_ws_skew_feeder on a 4x4 array.
// A behavioural weight-stationary array turns wests into souths.
module tb_systolic_ws_skew_feeder;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int C  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [DW-1:0] in_data [0:R-1];
  logic [DW-1:0] wests   [0:R-1];
  logic [4*DW-1:0] norths [0:C-1];
  logic [C-1:0]  sv;
  logic [C-1:0]  sl;
  logic          busy;
  logic          done;
`ifdef SYSTOLIC_WS_FEEDER_BIAS_EN
  logic [DW-1:0] in_bias [0:C-1];
`endif

  systolic_ws_skew_feeder #(
    .DATA_WIDTH (DW),
    .ROW_NUM    (R),
    .COL_NUM    (C)
  ) dut (
`ifdef SYSTOLIC_WS_FEEDER_BIAS_EN
    .in_bias     (in_bias),
`endif
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_data     (in_data),
    .wests       (wests),
    .norths      (norths),
    .south_valid (sv),
    .south_last  (sl),
    .busy        (busy),
    .done        (done)
  );

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(
    input string      name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Behavioural array model.
  int unsigned W [0:R-1][0:C-1];
  logic [31:0] a_q [0:R-1][0:C-1];
  logic [31:0] s_q [0:R-1][0:C-1];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) begin
          a_q[i][j] <= '0;
          s_q[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) begin
          logic [31:0] ain;
          logic [31:0] sin;
          ain = (j == 0) ? 32'(wests[i]) : a_q[i][j-1];
          sin = (i == 0) ? norths[j] : s_q[i-1][j];
          s_q[i][j] <= sin + ain * W[i][j];
          a_q[i][j] <= ain;
        end
    end
  end

  typedef struct {
    logic [31:0] v;
    logic        last;
  } exp_t;

  exp_t exp_q [C][$];

  // Monitor: pops one expectation per south_valid strobe.
  always @(negedge clk) begin
    if (reset) begin : mon
      exp_t e;
      logic exp_done;
      exp_done = 1'b0;
      for (int j = 0; j < C; j++) begin
        if (sv[j]) begin
          if (exp_q[j].size() == 0) begin
            check($sformatf("unexpected_col%0d", j),
                  64'd1, 64'd0);
          end else begin
            e = exp_q[j].pop_front();
            check($sformatf("south_col%0d", j),
                  64'(s_q[R-1][j]), 64'(e.v));
            check($sformatf("last_col%0d", j),
                  64'(sl[j]), 64'(e.last));
            if (j == C - 1) exp_done = e.last;
          end
        end else begin
          check($sformatf("last_idle_col%0d", j),
                64'(sl[j]), 64'd0);
        end
      end
      check("done", 64'(done), 64'(exp_done));
`ifndef SYSTOLIC_WS_FEEDER_BIAS_EN
      check("norths_zero",
            64'(|{norths[0], norths[1],
                  norths[2], norths[3]}), 64'd0);
`endif
    end
  end

  task automatic send(
    input  logic [0:R-1][7:0]  x,
    input  logic               last,
    input  logic [0:C-1][15:0] y,
    output int                 t0
  );
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_last  = last;
    for (int i = 0; i < R; i++) in_data[i] = x[i];
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    check("accept_wait", 64'(ok), 64'd1);
    t0 = edges;
    if (ok)
      for (int j = 0; j < C; j++)
        exp_q[j].push_back('{32'(y[j]), last});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < R; i++) in_data[i] = '0;
  endtask

  task automatic at_cycle(input int t);
    do @(negedge clk); while (edges < t);
  endtask

  function automatic bit queues_empty();
    for (int j = 0; j < C; j++)
      if (exp_q[j].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready && !busy && queues_empty()) begin
        ok = 1;
        break;
      end
    end
    check("idle_wait", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int diag, input int off);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        W[i][j] = (i == j) ? diag : off;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin : stim
    int t0;
    int tb;
    logic [0:R-1][7:0] x1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < R; i++) in_data[i] = '0;
`ifdef SYSTOLIC_WS_FEEDER_BIAS_EN
    for (int j = 0; j < C; j++) in_bias[j] = '0;
`endif
    set_w(1, 0);

    #1 reset = 1'b0;
    #2;
    for (int i = 0; i < R; i++)
      check("rst_wests", 64'(wests[i]), 64'd0);
    for (int j = 0; j < C; j++)
      check("rst_norths", 64'(norths[j]), 64'd0);
    check("rst_sv", 64'(sv), 64'd0);
    check("rst_sl", 64'(sl), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single vector, identity weights.
    x1 = {8'd1, 8'd2, 8'd3, 8'd4};
    send(x1, 1'b1,
         {16'd1, 16'd2, 16'd3, 16'd4}, t0);
    for (int c = 1; c <= 9; c++) begin
      at_cycle(t0 + c);
      for (int i = 0; i < R; i++)
        check($sformatf("single_west%0d_c%0d", i, c),
              64'(wests[i]),
              (c == i + 1) ? 64'(x1[i]) : 64'd0);
      check($sformatf("single_sv_c%0d", c), 64'(sv),
            (c >= 5 && c <= 8) ? 64'(1 << (c - 5))
                               : 64'd0);
      check($sformatf("single_done_c%0d", c),
            64'(done), 64'(c == 8));
      check($sformatf("single_ready_c%0d", c),
            64'(in_ready), 64'(c >= 9));
    end
    wait_idle();

    // Back-to-back, W = 2 on diagonal, 1 elsewhere.
    set_w(2, 1);
    send({8'd1, 8'd2, 8'd3, 8'd4}, 1'b0,
         {16'd11, 16'd12, 16'd13, 16'd14}, t0);
    send({8'd5, 8'd6, 8'd7, 8'd8}, 1'b0,
         {16'd31, 16'd32, 16'd33, 16'd34}, tb);
    send({8'd9, 8'd10, 8'd11, 8'd12}, 1'b1,
         {16'd51, 16'd52, 16'd53, 16'd54}, tb);
    check("b2b_third_cycle", 64'(tb - t0), 64'd2);
    for (int c = 3; c <= 11; c++) begin
      at_cycle(t0 + c);
      check($sformatf("b2b_sv0_c%0d", c), 64'(sv[0]),
            64'(c >= 5 && c <= 7));
      check($sformatf("b2b_done_c%0d", c),
            64'(done), 64'(c == 10));
      check($sformatf("b2b_ready_c%0d", c),
            64'(in_ready), 64'(c >= 11));
    end
    wait_idle();

    // Bubble between two vectors.
    set_w(1, 0);
    send({8'd7, 8'd0, 8'd5, 8'd3}, 1'b0,
         {16'd7, 16'd0, 16'd5, 16'd3}, t0);
    @(posedge clk);
    #1;
    send({8'd2, 8'd9, 8'd4, 8'd6}, 1'b1,
         {16'd2, 16'd9, 16'd4, 16'd6}, tb);
    for (int c = 3; c <= 8; c++) begin
      at_cycle(t0 + c);
      check($sformatf("bubble_sv0_c%0d", c), 64'(sv[0]),
            64'(c == 5 || c == 7));
    end
    wait_idle();

    // Backpressure: second vector held through DRAIN.
    send({8'd1, 8'd1, 8'd1, 8'd1}, 1'b1,
         {16'd1, 16'd1, 16'd1, 16'd1}, t0);
    send({8'd3, 8'd5, 8'd7, 8'd9}, 1'b1,
         {16'd3, 16'd5, 16'd7, 16'd9}, tb);
    check("bp_accept_cycle", 64'(tb - t0), 64'd9);
    wait_idle();

    // Reset in the middle of a batch.
    send({8'd4, 8'd4, 8'd4, 8'd4}, 1'b0,
         {16'd4, 16'd4, 16'd4, 16'd4}, t0);
    send({8'd6, 8'd6, 8'd6, 8'd6}, 1'b0,
         {16'd6, 16'd6, 16'd6, 16'd6}, tb);
    send({8'd8, 8'd8, 8'd8, 8'd8}, 1'b0,
         {16'd8, 16'd8, 16'd8, 16'd8}, tb);
    reset = 1'b0;
    for (int j = 0; j < C; j++) exp_q[j].delete();
    #1;
    for (int i = 0; i < R; i++)
      check("mid_rst_wests", 64'(wests[i]), 64'd0);
    check("mid_rst_sv", 64'(sv), 64'd0);
    check("mid_rst_sl", 64'(sl), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      check("post_rst_sv", 64'(sv), 64'd0);
      check("post_rst_done", 64'(done), 64'd0);
    end
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;

`ifdef SYSTOLIC_WS_FEEDER_BIAS_EN
    // Bias only, zero activations.
    in_bias[0] = 8'd10;
    in_bias[1] = 8'd20;
    in_bias[2] = 8'd30;
    in_bias[3] = 8'd40;
    send({8'd0, 8'd0, 8'd0, 8'd0}, 1'b1,
         {16'd10, 16'd20, 16'd30, 16'd40}, t0);
    for (int j = 0; j < C; j++) in_bias[j] = '0;
    wait_idle();
`endif

    check("queues_drained", 64'(queues_empty()), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_ws_skew_feeder.md
# systolic_ws_skew_feeder

Upstream feeder for `systolic_ws_pe_array`.
- Accepts one activation vector per beat over a valid/ready handshake.
- Skews the vector diagonally so row i of the array sees its element i cycles after row 0, and drives zeros on idle cycles.
- Tracks every vector through the array and asserts a per-column south-valid strobe, so downstream capture logic knows exactly when `souths[j]` holds a finished dot product.
- Also sequences batches: after the last vector of a batch it stops accepting input until the array has drained, and only then may weights change.

## Interface
Parameters:
- `DATA_WIDTH`, 8, activation/weight width; the array's north/south path is `4*DATA_WIDTH`.
- `ROW_NUM`, 8, array rows (number of vector elements).
- `COL_NUM`, 8, array columns.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  vector present.
- `in_ready`  out  1  feeder can accept a vector.
- `in_last`  in  1  the accepted vector is the final one of its batch.
- `in_data`  in  `DATA_WIDTH` x [0:ROW_NUM-1]  activation vector; element i goes to array row i.
- `wests`  out  `DATA_WIDTH` x [0:ROW_NUM-1]  skewed activations to the array.
- `norths`  out  `4*DATA_WIDTH` x [0:COL_NUM-1]  north seeds to the array (zero unless the bias feature is compiled in).
- `south_valid`  out  `COL_NUM`  bit j is high in the cycle that `souths[j]` is a valid result.
- `south_last`  out  `COL_NUM`  bit j is high with `south_valid[j]` for the batch's last vector.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when the batch's final result leaves column `COL_NUM-1`.

## Operation
- **Accept rule.** A vector is accepted on a rising edge where `in_valid && in_ready`.
- **Reset values.** Every output except `in_ready` resets to 0: `wests`, `norths`, `south_valid`, `south_last`, `busy`, `done`. `in_ready` resets to 1 and the state resets to IDLE.
- **State machine:**
  - IDLE: `in_ready`=1. An accept moves to STREAM. An accept with `in_last` moves to DRAIN.
  - STREAM: `in_ready`=1. An accept with `in_last` moves to DRAIN.
  - DRAIN: `in_ready`=0. When `done` pulses, move to IDLE.
- **Row skew.** Row i passes through a delay line of depth i+1, all stages registered. Cycles without an accept inject zeros at row 0 of the delay lines.
- **Valid/last pipeline.** A shift register of depth `ROW_NUM+COL_NUM` carries a {valid, last} pair per cycle.
  - `south_valid[j]` and `south_last[j]` are taken from tap `ROW_NUM+j`.
  - `done` = `south_valid[COL_NUM-1] && south_last[COL_NUM-1]`.
- **Bubbles.** Gaps in `in_valid` during STREAM produce zero vectors with valid=0; results stay correctly aligned.
- **Holding input.** `in_valid` during DRAIN holds (`in_ready`=0); `in_data` must stay stable, per the normal handshake rule.
- **Reset mid-operation.** All in-flight vectors are discarded, no `done` is produced, and the state returns to IDLE.
- **Simultaneous events.** `done` and a new `in_valid` in the same cycle: `in_ready` is still 0 that cycle, and the vector is accepted the next cycle from IDLE.
- **Arithmetic.** No arithmetic in the feeder; widths pass straight through. Bias is zero-extended to `4*DATA_WIDTH`.

## Timing
- Accept edge = cycle 0. `wests[i]` carries the element during cycle i+1.
- PE(i,j) captures at the end of cycle i+j+1, so `souths[j]` is valid during cycle `ROW_NUM+j+1`.
- `south_valid[j]` is asserted exactly in that cycle, for one cycle per vector.
- Throughput: one vector per cycle in STREAM.
- Last vector accepted at cycle 0 → `done` pulses in cycle `ROW_NUM+COL_NUM`, and `in_ready` returns in cycle `ROW_NUM+COL_NUM+1`.
- Weights may change from the cycle after `done` onward.

## Configuration
- `SYSTOLIC_WS_FEEDER_BIAS_EN` defined:
  - Adds input `in_bias`, `DATA_WIDTH` x [0:COL_NUM-1], sampled with `in_data`.
  - Column j's bias goes through a delay line of depth j+1 and drives `norths[j]` zero-extended, aligned with the west data at PE(0,j).
  - Idle cycles inject zero bias.
- Undefined: no `in_bias` port, and `norths` is tied to 0.

## Structure
- Package `systolic_ws_pkg` holds:
  - the state enum (IDLE, STREAM, DRAIN);
  - localparam `PIPE_DEPTH = ROW_NUM+COL_NUM`;
  - function `south_latency(j) = ROW_NUM+j+1`.
- Sub-module `systolic_ws_delay_line` (parameters `WIDTH`, `DEPTH`; async active-low reset to 0).
  - Instantiated per row for `wests`, per column for bias, and once, 2 bits wide, for the valid/last pipeline.

## Test plan
All scenarios use `ROW_NUM`=`COL_NUM`=4 and `DATA_WIDTH`=8, with the feeder connected to `systolic_ws_pe_array`.
- **Single vector.** Identity weights; input {1,2,3,4} with `in_last` at cycle 0 → `wests[i]` nonzero only in cycle i+1; `south_valid[j]` pulses in cycle 5+j with `souths[j]`=j+1; `done` pulses in cycle 8; `in_ready` returns in cycle 9.
- **Back-to-back.** 3 vectors in consecutive cycles, last on the third → 3 consecutive `south_valid[0]` pulses in cycles 5–7; `done` pulses in cycle 10; all products match the reference matmul.
- **Bubble.** Vector, idle cycle, vector (last) → `south_valid[0]` pulses in cycles 5 and 7 only; no result is corrupted.
- **Backpressure.** `in_valid` held during DRAIN → no accept until `in_ready` rises; `in_data` is consumed exactly once.
- **Reset mid-stream.** Assert `reset` low at cycle 3 of a batch → all outputs are 0 and IDLE immediately; no `done` follows.
- **Bias** (`SYSTOLIC_WS_FEEDER_BIAS_EN`). Bias {10,20,30,40} with an all-zero activation vector → `souths[j]`=bias[j] at `south_valid[j]`.
